// File: rtl/stall_pkg.sv
// -----------------------------------------------------------------------------
// stall_pkg
// Shared constants and helpers for the pipeline stall controller.
//   MD_MULT_CYCLES : busy period loaded for a multiply
//   MD_DIV_CYCLES  : busy period loaded for a divide
//   TUSE_NONE      : tuse encoding meaning "operand not read"
//   src_hazard()   : one source-vs-one-producer RAW hazard compare
// -----------------------------------------------------------------------------
package stall_pkg;

   localparam logic [3:0] MD_MULT_CYCLES = 4'd5;
   localparam logic [3:0] MD_DIV_CYCLES  = 4'd10;
   localparam logic [1:0] TUSE_NONE      = 2'd3;

   typedef enum logic {
      MD_OP_MULT = 1'b0,
      MD_OP_DIV  = 1'b1
   } md_op_e;

   // A read of src at tuse hazards against a producer writing dst with tnew
   // cycles left when the result arrives later than it is needed. $0 is never
   // a real dependency. TUSE_NONE can never lose to tnew (tnew <= 2), the
   // explicit test just makes the intent obvious.
   function automatic logic src_hazard(
      input logic [4:0] src,
      input logic [1:0] tuse,
      input logic [4:0] dst,
      input logic [1:0] tnew
   );
      logic w_hit;
      w_hit = (src != 5'd0) && (tuse != TUSE_NONE) && (src == dst) && (tnew > tuse);
      return w_hit;
   endfunction

endpackage

// File: rtl/md_busy_timer.sv
// -----------------------------------------------------------------------------
// md_busy_timer
// Down-counter modelling the occupancy of the multiply/divide unit.
// Ports:
//   clk   in  1  clock, posedge
//   reset in  1  synchronous, active-high; clears the count
//   start in  1  mult/div issued this cycle (ignored while busy)
//   op    in  1  0 = mult, 1 = div
//   busy  out 1  count is nonzero
// -----------------------------------------------------------------------------
module md_busy_timer
   import stall_pkg::*;
(
   input  logic clk,
   input  logic reset,
   input  logic start,
   input  logic op,
   output logic busy
);

   logic [3:0] r_md_cnt;
   logic [3:0] w_md_cnt_nxt;
   logic [3:0] w_load_val;

   // Next count: load only from idle, otherwise count down and stop at zero.
   // A start arriving while the count is still nonzero (including the last
   // busy cycle) is dropped; it neither reloads nor extends the period.
   always_comb begin
      w_load_val   = MD_MULT_CYCLES;
      w_md_cnt_nxt = r_md_cnt;
      if (md_op_e'(op) == MD_OP_DIV) begin
         w_load_val = MD_DIV_CYCLES;
      end else begin
         w_load_val = MD_MULT_CYCLES;
      end
      if (r_md_cnt == 4'd0) begin
         if (start) begin
            w_md_cnt_nxt = w_load_val;
         end else begin
            w_md_cnt_nxt = 4'd0;
         end
      end else begin
         w_md_cnt_nxt = r_md_cnt - 4'd1;
      end
   end

   // Count register with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_md_cnt <= 4'd0;
      end else begin
         r_md_cnt <= w_md_cnt_nxt;
      end
   end

   assign busy = (r_md_cnt != 4'd0);

endmodule

// File: rtl/stall_ctrl.sv
// -----------------------------------------------------------------------------
// stall_ctrl
// Decode-stage interlock: stalls F/D and bubbles E on RAW hazards against the
// E and M stage producers, and while the multiply/divide unit is occupied.
// Ports:
//   clk, reset               clock and synchronous active-high reset
//   D_rs_addr, D_rt_addr     D-stage source registers
//   D_rs_tuse, D_rt_tuse     cycles until each source is needed (3 = unused)
//   D_is_md                  D instruction uses HI/LO
//   E_dst_addr, E_tnew       E-stage producer and cycles until ready
//   M_dst_addr, M_tnew       M-stage producer and cycles until ready
//   E_md_start, E_md_op      mult/div issued in E (op: 0 = mult, 1 = div)
//   PC_WE, D_WE              write enables, low while stalled
//   E_clr                    bubble insert into E
//   md_busy                  mult/div unit occupied
//   stall_cnt (optional)     32-bit count of stalled cycles, wraps
// Configuration: define STALL_CTRL_PERF_EN to add the stall_cnt output.
// -----------------------------------------------------------------------------
module stall_ctrl
   import stall_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic [4:0]  D_rs_addr,
   input  logic [4:0]  D_rt_addr,
   input  logic [1:0]  D_rs_tuse,
   input  logic [1:0]  D_rt_tuse,
   input  logic        D_is_md,
   input  logic [4:0]  E_dst_addr,
   input  logic [1:0]  E_tnew,
   input  logic [4:0]  M_dst_addr,
   input  logic [1:0]  M_tnew,
   input  logic        E_md_start,
   input  logic        E_md_op,
   output logic        PC_WE,
   output logic        D_WE,
   output logic        E_clr,
   output logic        md_busy
`ifdef STALL_CTRL_PERF_EN
   ,
   output logic [31:0] stall_cnt
`endif
);

   logic w_md_busy;
   logic w_stall_rs;
   logic w_stall_rt;
   logic w_stall_md;
   logic w_stall;

   md_busy_timer u_md_busy_timer (
      .clk   (clk),
      .reset (reset),
      .start (E_md_start),
      .op    (E_md_op),
      .busy  (w_md_busy)
   );

   // Hazard decode. The outputs follow this decode even while reset is held;
   // reset only affects the mult/div count (and the perf counter).
   always_comb begin
      w_stall_rs = src_hazard(D_rs_addr, D_rs_tuse, E_dst_addr, E_tnew) ||
                   src_hazard(D_rs_addr, D_rs_tuse, M_dst_addr, M_tnew);
      w_stall_rt = src_hazard(D_rt_addr, D_rt_tuse, E_dst_addr, E_tnew) ||
                   src_hazard(D_rt_addr, D_rt_tuse, M_dst_addr, M_tnew);
      // A start in E this cycle has not reached the counter yet, so it must
      // block a HI/LO user in D directly.
      w_stall_md = D_is_md && (w_md_busy || E_md_start);
      w_stall    = w_stall_rs || w_stall_rt || w_stall_md;
   end

   assign PC_WE   = ~w_stall;
   assign D_WE    = ~w_stall;
   assign E_clr   = w_stall;
   assign md_busy = w_md_busy;

`ifdef STALL_CTRL_PERF_EN
   logic [31:0] r_stall_cnt;

   // Stalled-cycle counter; wraps naturally at 32 bits.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_stall_cnt <= 32'd0;
      end else if (w_stall) begin
         r_stall_cnt <= r_stall_cnt + 32'd1;
      end else begin
         r_stall_cnt <= r_stall_cnt;
      end
   end

   assign stall_cnt = r_stall_cnt;
`endif

endmodule

// File: tb/tb_stall_ctrl.sv
// -----------------------------------------------------------------------------
// tb_stall_ctrl
// Directed-vector bench for stall_ctrl. Inputs change 1 time unit after the
// rising edge; outputs are sampled a further 1-2 units later.
// Define STALL_CTRL_PERF_EN to also exercise the stall counter.
// -----------------------------------------------------------------------------
module tb_stall_ctrl;

   logic        clk;
   logic        reset;
   logic [4:0]  D_rs_addr;
   logic [4:0]  D_rt_addr;
   logic [1:0]  D_rs_tuse;
   logic [1:0]  D_rt_tuse;
   logic        D_is_md;
   logic [4:0]  E_dst_addr;
   logic [1:0]  E_tnew;
   logic [4:0]  M_dst_addr;
   logic [1:0]  M_tnew;
   logic        E_md_start;
   logic        E_md_op;
   logic        PC_WE;
   logic        D_WE;
   logic        E_clr;
   logic        md_busy;
`ifdef STALL_CTRL_PERF_EN
   logic [31:0] stall_cnt;
`endif

   int n_cmp;
   int n_err;

   stall_ctrl dut (
      .clk        (clk),
      .reset      (reset),
      .D_rs_addr  (D_rs_addr),
      .D_rt_addr  (D_rt_addr),
      .D_rs_tuse  (D_rs_tuse),
      .D_rt_tuse  (D_rt_tuse),
      .D_is_md    (D_is_md),
      .E_dst_addr (E_dst_addr),
      .E_tnew     (E_tnew),
      .M_dst_addr (M_dst_addr),
      .M_tnew     (M_tnew),
      .E_md_start (E_md_start),
      .E_md_op    (E_md_op),
      .PC_WE      (PC_WE),
      .D_WE       (D_WE),
      .E_clr      (E_clr),
      .md_busy    (md_busy)
`ifdef STALL_CTRL_PERF_EN
      ,
      .stall_cnt  (stall_cnt)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      n_cmp = n_cmp + 1;
      if (obs !== exp_v) begin
         n_err = n_err + 1;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
      end
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_hz();
      D_rs_addr  = 5'd0;
      D_rt_addr  = 5'd0;
      D_rs_tuse  = 2'd3;
      D_rt_tuse  = 2'd3;
      E_dst_addr = 5'd0;
      E_tnew     = 2'd0;
      M_dst_addr = 5'd0;
      M_tnew     = 2'd0;
   endtask

   // Apply one hazard vector and check the three decode outputs.
   task automatic hz_vec(input string tag,
                         input logic [4:0] rs, input logic [1:0] rs_tu,
                         input logic [4:0] rt, input logic [1:0] rt_tu,
                         input logic [4:0] ed, input logic [1:0] et,
                         input logic [4:0] md, input logic [1:0] mt,
                         input logic exp_stall);
      D_rs_addr  = rs;
      D_rs_tuse  = rs_tu;
      D_rt_addr  = rt;
      D_rt_tuse  = rt_tu;
      E_dst_addr = ed;
      E_tnew     = et;
      M_dst_addr = md;
      M_tnew     = mt;
      #1;
      check({tag, ".PC_WE"}, {31'd0, PC_WE}, {31'd0, ~exp_stall});
      check({tag, ".D_WE"},  {31'd0, D_WE},  {31'd0, ~exp_stall});
      check({tag, ".E_clr"}, {31'd0, E_clr}, {31'd0, exp_stall});
   endtask

   initial begin
      n_cmp      = 0;
      n_err      = 0;
      reset      = 1'b1;
      D_is_md    = 1'b0;
      E_md_start = 1'b0;
      E_md_op    = 1'b0;
      clear_hz();

      // Reset state, and decode live while reset is held.
      next_cycle();
      next_cycle();
      check("rst.md_busy", {31'd0, md_busy}, 32'd0);
      check("rst.PC_WE",   {31'd0, PC_WE},   32'd1);
      hz_vec("rst.loaduse", 5'd8, 2'd0, 5'd0, 2'd3, 5'd8, 2'd2, 5'd0, 2'd0, 1'b1);
      clear_hz();
      next_cycle();
      reset = 1'b0;
      next_cycle();

      // Combinational hazard vectors.
      hz_vec("loaduse",    5'd8,  2'd0, 5'd0,  2'd3, 5'd8,  2'd2, 5'd0, 2'd0, 1'b1);
      hz_vec("loaduse_e0", 5'd8,  2'd0, 5'd0,  2'd3, 5'd0,  2'd2, 5'd0, 2'd0, 1'b0);
      hz_vec("zero_rt",    5'd0,  2'd3, 5'd0,  2'd0, 5'd0,  2'd2, 5'd0, 2'd0, 1'b0);
      hz_vec("tuse_none",  5'd8,  2'd3, 5'd0,  2'd3, 5'd8,  2'd2, 5'd0, 2'd0, 1'b0);
      hz_vec("m_rt",       5'd0,  2'd3, 5'd9,  2'd1, 5'd0,  2'd0, 5'd9, 2'd2, 1'b1);
      hz_vec("m_rt_eq",    5'd0,  2'd3, 5'd9,  2'd1, 5'd0,  2'd0, 5'd9, 2'd1, 1'b0);
      hz_vec("e_rs_t1",    5'd5,  2'd0, 5'd0,  2'd3, 5'd5,  2'd1, 5'd0, 2'd0, 1'b1);
      hz_vec("addr_miss",  5'd5,  2'd0, 5'd0,  2'd3, 5'd6,  2'd2, 5'd0, 2'd0, 1'b0);
      hz_vec("e_rt31",     5'd0,  2'd3, 5'd31, 2'd0, 5'd31, 2'd1, 5'd0, 2'd0, 1'b1);
      hz_vec("tnew0",      5'd4,  2'd0, 5'd0,  2'd3, 5'd4,  2'd0, 5'd0, 2'd0, 1'b0);
      clear_hz();

      // Multiply: start at cycle t, busy t+1..t+5, HI/LO user stalls t..t+5.
      next_cycle();
      E_md_start = 1'b1;
      E_md_op    = 1'b0;
      D_is_md    = 1'b1;
      #1;
      check("mult.t.PC_WE",   {31'd0, PC_WE},   32'd0);
      check("mult.t.md_busy", {31'd0, md_busy}, 32'd0);
      next_cycle();
      E_md_start = 1'b0;
      for (int k = 1; k <= 6; k++) begin
         #1;
         check($sformatf("mult.t+%0d.md_busy", k), {31'd0, md_busy}, (k <= 5) ? 32'd1 : 32'd0);
         check($sformatf("mult.t+%0d.PC_WE", k),   {31'd0, PC_WE},   (k <= 5) ? 32'd0 : 32'd1);
         next_cycle();
      end
      D_is_md = 1'b0;

      // Divide with extra starts at t+3 and t+10 (last busy cycle): both
      // ignored, busy falls at t+11 and stays low.
      E_md_start = 1'b1;
      E_md_op    = 1'b1;
      next_cycle();
      for (int k = 1; k <= 12; k++) begin
         if (k == 3 || k == 10) begin
            E_md_start = 1'b1;
            E_md_op    = 1'b0;
         end else begin
            E_md_start = 1'b0;
         end
         #1;
         check($sformatf("div.t+%0d.md_busy", k), {31'd0, md_busy}, (k <= 10) ? 32'd1 : 32'd0);
         next_cycle();
      end
      E_md_start = 1'b0;

      // Reset in the middle of a divide.
      E_md_start = 1'b1;
      E_md_op    = 1'b1;
      next_cycle();
      E_md_start = 1'b0;
      for (int k = 1; k <= 3; k++) begin
         #1;
         check($sformatf("rdiv.t+%0d.md_busy", k), {31'd0, md_busy}, 32'd1);
         next_cycle();
      end
      reset   = 1'b1;
      D_is_md = 1'b1;
      #1;
      check("rdiv.t+4.md_busy", {31'd0, md_busy}, 32'd1);
      check("rdiv.t+4.E_clr",   {31'd0, E_clr},   32'd1);
      next_cycle();
      reset = 1'b0;
      #1;
      check("rdiv.t+5.md_busy", {31'd0, md_busy}, 32'd0);
      check("rdiv.t+5.PC_WE",   {31'd0, PC_WE},   32'd1);
      check("rdiv.t+5.E_clr",   {31'd0, E_clr},   32'd0);
      D_is_md = 1'b0;
      next_cycle();

`ifdef STALL_CTRL_PERF_EN
      // Counter was cleared by the reset above; count exactly 7 stalls.
      check("perf.zero", stall_cnt, 32'd0);
      D_rs_addr  = 5'd8;
      D_rs_tuse  = 2'd0;
      E_dst_addr = 5'd8;
      E_tnew     = 2'd2;
      for (int k = 0; k < 7; k++) begin
         next_cycle();
      end
      clear_hz();
      #1;
      check("perf.seven", stall_cnt, 32'd7);
      next_cycle();
      check("perf.hold", stall_cnt, 32'd7);
      force dut.r_stall_cnt = 32'hFFFF_FFFE;
      #1;
      release dut.r_stall_cnt;
      D_rs_addr  = 5'd8;
      D_rs_tuse  = 2'd0;
      E_dst_addr = 5'd8;
      E_tnew     = 2'd2;
      next_cycle();
      check("perf.max", stall_cnt, 32'hFFFF_FFFF);
      next_cycle();
      clear_hz();
      #1;
      check("perf.wrap", stall_cnt, 32'd0);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
